// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB bus arbiter: grants one of NUM_MASTERS masters, honouring fixed-length bursts and locked sequences.
// Latency: a request seen while arbitration is open reaches hgrant after 1 accepted edge and hmaster after the next one.
// Backpressure: hready=0 freezes every register (grant, owner, lock flag, beat counter, FSM).
//
// Ports:
//   Hclk, Hreset      bus clock (rising edge), asynchronous active-low reset
//   hbusreq, hlock    per-master request and locked-transfer request
//   htrans, hburst    transfer type / burst type of the current owner
//   hready, hresp     bus advance and ERROR response
//   hgrant            registered one-hot grant
//   hmaster           registered address-phase owner index
//   hmastlock         registered lock indication for the current owner
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = 2
) (
    input  logic                   Hclk,
    input  logic                   Hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic                   hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] GRANT_ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BURST,
        ARB_LOCKED
    } arb_state_t;

    arb_state_t      state;
    logic [MW-1:0]   gidx;
    logic [3:0]      beat_cnt;

    logic [3:0]      cnt_nxt;
    logic [MW-1:0]   rr_next;
    logic            arb_ok;
    logic            lock_cur;
    logic            fixed_burst;

    // Beats remaining after the NONSEQ beat; SINGLE and INCR are both 0,
    // so undefined-length bursts stay re-arbitrable every beat.
    function automatic logic [3:0] burst_last(input logic [2:0] b);
        logic [3:0] r;
        case (b[2:1])
            2'b01:   r = 4'd3;
            2'b10:   r = 4'd7;
            2'b11:   r = 4'd15;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    assign fixed_burst = (hburst[2:1] != 2'b00);
    assign lock_cur    = hlock[hmaster];

    // An accepted ERROR response opens arbitration even mid-burst; a locked
    // sequence never does.
    assign arb_ok = (state != ARB_LOCKED) &&
                    ((state == ARB_IDLE) ||
                     ((state == ARB_BURST) && (beat_cnt <= 4'd1)) ||
                     hresp);

    always_comb begin
        cnt_nxt = beat_cnt;
        if (hresp) begin
            cnt_nxt = 4'd0;
        end else if (htrans == TRANS_NONSEQ) begin
            cnt_nxt = burst_last(hburst);
        end else if ((htrans == TRANS_SEQ) && (beat_cnt != 4'd0)) begin
            cnt_nxt = beat_cnt - 4'd1;
        end
    end

    // Scan gidx+1 .. gidx cyclically; the current owner is checked last so
    // that a lone requester keeps the bus and others rotate ahead of it.
    always_comb begin
        logic found;
        logic [MW-1:0] cand;
        rr_next = DEF_IDX;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = MW'((int'(gidx) + i) % NUM_MASTERS);
            if (!found && hbusreq[cand]) begin
                rr_next = cand;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            state     <= ARB_IDLE;
            gidx      <= DEF_IDX;
            hgrant    <= GRANT_ONE << DEF_IDX;
            hmaster   <= DEF_IDX;
            hmastlock <= 1'b0;
            beat_cnt  <= 4'd0;
        end else if (hready) begin
            // Address-phase ownership follows the grant one accepted edge later.
            hmaster   <= gidx;
            hmastlock <= hlock[gidx];
            beat_cnt  <= cnt_nxt;

            if (arb_ok) begin
                gidx   <= rr_next;
                hgrant <= GRANT_ONE << rr_next;
            end

            if (lock_cur) begin
                state <= ARB_LOCKED;
            end else if (hresp) begin
                state <= ARB_IDLE;
            end else begin
                case (state)
                    ARB_IDLE: begin
                        if ((htrans == TRANS_NONSEQ) && fixed_burst) begin
                            state <= ARB_BURST;
                        end
                    end
                    ARB_BURST: begin
                        if ((htrans == TRANS_IDLE) ||
                            ((htrans == TRANS_SEQ) && (beat_cnt == 4'd1))) begin
                            state <= ARB_IDLE;
                        end
                    end
                    ARB_LOCKED: begin
                        // Lock released: hand back to arbitration only once
                        // the locked burst has no beats left.
                        if (cnt_nxt == 4'd0) begin
                            state <= ARB_IDLE;
                        end
                    end
                    default: state <= ARB_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: reset/park, round-robin, INCR4 hold,
// WRAP8 with wait states, locked bursts and ERROR abort.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_ahb_rr_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_WRAP8  = 3'b100;
    localparam logic [2:0] B_INCR16 = 3'b111;

    logic       Hclk = 1'b0;
    logic       Hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic       hresp;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;

    ahb_rr_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0),
        .MW             (2)
    ) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Hclk);
        #1;
    endtask

    task automatic idle_inputs;
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        htrans  = T_IDLE;
        hburst  = B_SINGLE;
        hready  = 1'b1;
        hresp   = 1'b0;
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any edge.
    task automatic pulse_reset;
        idle_inputs();
        Hreset = 1'b0;
        #2;
        Hreset = 1'b1;
        #1;
    endtask

    initial begin
        logic [3:0] rr_grant  [4];
        logic [1:0] rr_master [4];
        rr_grant  = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
        rr_master = '{2'd0, 2'd1, 2'd2, 2'd1};

        idle_inputs();
        Hreset = 1'b0;
        tick();
        check("rst_grant", hgrant, 4'b0001);
        check("rst_master", hmaster, 2'd0);
        check("rst_lock", hmastlock, 1'b0);
        Hreset = 1'b1;
        repeat (3) tick();
        check("park_grant", hgrant, 4'b0001);

        // Round robin between masters 1 and 2 with SINGLE transfers.
        hbusreq = 4'b0110;
        htrans  = T_NONSEQ;
        hburst  = B_SINGLE;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr_grant%0d", i), hgrant, rr_grant[i]);
            check($sformatf("rr_master%0d", i), hmaster, rr_master[i]);
        end

        // Reset asserted mid-cycle acts without a clock edge.
        #2;
        Hreset = 1'b0;
        #1;
        check("arst_grant", hgrant, 4'b0001);
        check("arst_master", hmaster, 2'd0);
        check("arst_lock", hmastlock, 1'b0);
        Hreset = 1'b1;
        idle_inputs();
        tick();

        // INCR4 owned by master 1; master 3 joins on beat 1.
        pulse_reset();
        hbusreq = 4'b0010;
        tick();
        check("i4_grant1", hgrant, 4'b0010);
        tick();
        check("i4_owner", hmaster, 2'd1);
        htrans = T_NONSEQ;
        hburst = B_INCR4;
        tick();
        check("i4_cnt0", dut.beat_cnt, 4'd3);
        htrans  = T_SEQ;
        hbusreq = 4'b1010;
        tick();
        check("i4_hold_b1", hgrant, 4'b0010);
        tick();
        check("i4_hold_b2", hgrant, 4'b0010);
        hbusreq = 4'b1000;
        tick();
        check("i4_handoff", hgrant, 4'b1000);
        check("i4_master_b3", hmaster, 2'd1);
        check("i4_cnt_end", dut.beat_cnt, 4'd0);
        htrans = T_IDLE;
        tick();
        check("i4_new_owner", hmaster, 2'd3);

        // WRAP8 on master 0 with three wait states after beat 1.
        pulse_reset();
        hbusreq = 4'b0001;
        tick();
        htrans = T_NONSEQ;
        hburst = B_WRAP8;
        tick();
        check("w8_cnt_ns", dut.beat_cnt, 4'd7);
        htrans = T_SEQ;
        tick();
        check("w8_cnt_s1", dut.beat_cnt, 4'd6);
        hbusreq = 4'b0011;
        hready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("w8_wait_cnt%0d", i), dut.beat_cnt, 4'd6);
            check($sformatf("w8_wait_grant%0d", i), hgrant, 4'b0001);
            check($sformatf("w8_wait_master%0d", i), hmaster, 2'd0);
        end
        hready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("w8_cnt_s%0d", i + 2), dut.beat_cnt, 32'(5 - i));
            check($sformatf("w8_grant_s%0d", i + 2), hgrant, 4'b0001);
        end
        tick();
        check("w8_cnt_last", dut.beat_cnt, 4'd0);
        check("w8_handoff", hgrant, 4'b0010);

        // Master 2 locked across two INCR4 bursts while master 0 waits.
        pulse_reset();
        hbusreq = 4'b0100;
        hlock   = 4'b0100;
        tick();
        check("lk_grant", hgrant, 4'b0100);
        tick();
        check("lk_master", hmaster, 2'd2);
        check("lk_mastlock", hmastlock, 1'b1);
        tick();
        hbusreq = 4'b0101;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                htrans = (k == 0) ? T_NONSEQ : T_SEQ;
                hburst = B_INCR4;
                if (b == 1 && k == 3) hlock = 4'b0000;
                tick();
                check($sformatf("lk_grant_b%0d_%0d", b, k), hgrant, 4'b0100);
                if (!(b == 1 && k == 3))
                    check($sformatf("lk_ml_b%0d_%0d", b, k), hmastlock, 1'b1);
            end
        end
        check("lk_ml_drop", hmastlock, 1'b0);
        htrans = T_IDLE;
        tick();
        check("lk_release", hgrant, 4'b0001);

        // INCR16 on master 1 aborted by a two-cycle ERROR on beat 2.
        pulse_reset();
        hbusreq = 4'b0010;
        repeat (2) tick();
        htrans = T_NONSEQ;
        hburst = B_INCR16;
        tick();
        check("er_cnt_ns", dut.beat_cnt, 4'd15);
        hbusreq = 4'b0011;
        htrans  = T_SEQ;
        tick();
        hresp  = 1'b1;
        hready = 1'b0;
        tick();
        check("er_first_grant", hgrant, 4'b0010);
        check("er_first_cnt", dut.beat_cnt, 4'd14);
        hready = 1'b1;
        tick();
        check("er_grant", hgrant, 4'b0001);
        check("er_cnt", dut.beat_cnt, 4'd0);
        check("er_master", hmaster, 2'd1);
        hresp  = 1'b0;
        htrans = T_IDLE;
        tick();
        check("er_new_owner", hmaster, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
Round-robin AHB bus arbiter that shares the single AHB address/data path between up to NUM_MASTERS bus masters. In the AHB-to-I2C subsystem this covers the CPU-side master and DMA-style masters feeding the I2C bridge slave.
It tracks fixed-length bursts and locked sequences so that ownership only moves on legal boundaries. It drives one-hot grants, the current address-phase owner index and the master-lock indication.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, master parked on the bus when nobody requests
MW, 2, width of hmaster; must equal ceil(log2(NUM_MASTERS))

Ports:
Hclk  input  1  bus clock, rising edge
Hreset  input  1  asynchronous active-low reset
hbusreq  input  NUM_MASTERS  per-master bus request, level
hlock  input  NUM_MASTERS  per-master locked-transfer request
htrans  input  2  muxed transfer type of current owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
hburst  input  3  muxed burst type of current owner
hready  input  1  transfer done / bus advance
hresp  input  1  1 = ERROR response
hgrant  output  NUM_MASTERS  one-hot grant, registered
hmaster  output  MW  index of address-phase owner, registered
hmastlock  output  1  current owner's transfer is locked, registered

Behaviour:
- Clock and reset: reset is Hreset, asynchronous, active-low; clock is Hclk.
- Reset values:
  - hgrant = one-hot(DEFAULT_MASTER)
  - hmaster = DEFAULT_MASTER
  - hmastlock = 0
  - beat counter = 0
  - state = ARB_IDLE
- Internal state:
  - gidx: granted index; hgrant = one-hot(gidx).
  - beat_cnt: 4 bits.
  - FSM with states ARB_IDLE, ARB_BURST, ARB_LOCKED.
- Stall rule: all registers update only on posedge Hclk with hready=1. With hready=0, every output and all state hold.
- Ownership handoff:
  - At posedge with hready=1: hmaster <= gidx and hmastlock <= hlock[gidx].
  - hmaster therefore lags hgrant by one accepted cycle, per AHB address-phase handover.
- Beat counting (posedge, hready=1):
  - htrans=NONSEQ: beat_cnt <= beats-1. SINGLE=0, INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15, INCR(001)=0 (undefined length, re-arbitrable every beat).
  - htrans=SEQ with beat_cnt>0: decrement.
  - BUSY or IDLE: beat_cnt holds.
- FSM transitions:
  - ARB_IDLE -> ARB_BURST: NONSEQ accepted with a fixed-length hburst.
  - ARB_BURST -> ARB_IDLE: the accepted beat has beat_cnt==1 (last beat now in address phase), or IDLE is accepted.
  - Any state -> ARB_LOCKED: hlock[hmaster]=1 is sampled.
  - ARB_LOCKED -> ARB_IDLE: hlock[hmaster]=0 and no burst beats remain.
- Arbitration permitted (arb_ok) when:
  - state=ARB_IDLE, or
  - state=ARB_BURST and beat_cnt<=1, or
  - hresp=1 with hready=1. An error aborts the burst: beat_cnt <= 0 and state <= ARB_IDLE, or ARB_LOCKED if hlock is still held.
  - Never while in ARB_LOCKED.
- Round-robin selection, evaluated when arb_ok and hready=1:
  - Scan indices gidx+1, gidx+2, ... cyclically, NUM_MASTERS entries, ending with gidx itself.
  - The first index with hbusreq=1 becomes the new gidx.
  - If no request is present, gidx <= DEFAULT_MASTER (park).
  - A lone requester keeps the grant indefinitely.
  - Priority rotates so every requester is granted within NUM_MASTERS arbitration points.
- Simultaneous events:
  - A new request during the final burst beat is granted at that same edge, so there are no idle bubbles between bursts.
  - hresp=1 together with hready=0 (first error cycle) is ignored; only the second cycle (hready=1) acts.
- Reset mid-burst: all state returns to reset values immediately; the in-flight burst is abandoned.
- Latency: a request presented while arb_ok=1 appears on hgrant after 1 edge and on hmaster after the next accepted edge.

Test Plan:
- Reset: Hreset=0 mid-cycle -> hgrant=4'b0001, hmaster=0, hmastlock=0 asynchronously. With no requests after release, the grant stays parked on master 0.
- Round-robin: hbusreq=4'b0110, SINGLE NONSEQ each beat -> gidx sequence 1,2,1,2. hmaster follows one edge later.
- INCR4 burst: master 1 owns the bus, NONSEQ+3 SEQ, master 3 requests on beat 1 -> hgrant stays 4'b0010 until the edge accepting beat 3, then 4'b1000.
- Wait states: hready=0 for 3 cycles during a WRAP8 beat -> hgrant, hmaster and beat_cnt frozen; with hready=1 the burst resumes and 8 beats are counted.
- Lock: master 2 holds hlock through two INCR4 bursts while master 0 requests -> hmastlock=1 throughout and no grant to master 0. Master 0 is granted on the first edge after hlock[2] falls at the burst end.
- Error abort: hresp=1 on beat 2 of an INCR16 with master 0 waiting -> after the hready=1 error cycle the grant moves to master 0 on that edge, and beat_cnt=0.
